// File: rtl/apb_cmd_master_if.sv
// Bundle of the command, response and APB master signals of apb_cmd_master.
// The master modport is the block's view; slave is the command source and APB target side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB master with a registered response slot.
// Define APB_CMD_MASTER_TIMEOUT_EN to bound PREADY-low cycles in ACCESS by TIMEOUT.
module apb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_cmd_master_if.master bus
);
  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | APB setup phase, PSEL=1 PENABLE=0
  // ACCESS | APB access phase, waiting for PREADY
  // RESP   | response held until rsp_ready
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT must be in 1..255");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timeout_hit;

  assign bus.cmd_ready = (state_q == ST_IDLE) && !PRESET;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic       rsp_to_q, rsp_to_d;

  // The current low cycle is counted, so the limit fires on the TIMEOUT-th low cycle.
  assign wait_inc        = wait_cnt_q + 8'd1;
  assign timeout_hit     = (state_q == ST_ACCESS) && !bus.PREADY && (wait_inc == TIMEOUT_C);
  assign bus.rsp_timeout = rsp_to_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rsp_to_d   = rsp_to_q;
    if (accept) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_ACCESS && !bus.PREADY) begin
      wait_cnt_d = wait_inc;
    end
    if (state_q == ST_ACCESS && (bus.PREADY || timeout_hit)) begin
      rsp_to_d = !bus.PREADY;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_to_q   <= rsp_to_d;
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d = ST_RESP;
          rdata_d = pwrite_q ? '0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.PENABLE   = (state_q == ST_ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed cases plus randomized transactions
// checked against a transaction-level timing/result model.
module tb_apb_cmd_master;
  localparam int TB_TIMEOUT = 4;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_cmd_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic junk_apb();
    bus.PREADY  = 1'($urandom);
    bus.PRDATA  = 8'($urandom);
    bus.PSLVERR = 1'($urandom);
  endtask

  task automatic junk_cmd();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = 8'($urandom);
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    junk_cmd();
    junk_apb();
    bus.rsp_ready = 1'($urandom);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_timeout", bus.rsp_timeout, 0);
    PRESET        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_release_ready", bus.cmd_ready, 1);
  endtask

  // One transaction: w = PREADY-low cycles the target inserts, d = cycles rsp_ready stays low.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int w, input logic [7:0] prd, input logic slv, input int d);
    int         acc_exp;
    logic       to_exp;
    logic [7:0] rd_exp;
    logic       err_exp;
    int         lat, psel, pen, acc;
    logic       stable, held;
    acc_exp = w + 1;
    to_exp  = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    if (w >= TB_TIMEOUT) begin
      acc_exp = TB_TIMEOUT;
      to_exp  = 1'b1;
    end
`endif
    rd_exp  = (to_exp || wr) ? 8'h00 : prd;
    err_exp = to_exp ? 1'b1 : slv;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.rsp_ready = 1'b0;
    junk_apb();
    chk("accept_ready", bus.cmd_ready, 1);
    step();
    lat = 1; psel = 0; pen = 0; acc = 0; stable = 1'b1;
    while (!bus.rsp_valid && lat < 300) begin
      junk_cmd();
      if (bus.PSEL) begin
        psel++;
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata) stable = 1'b0;
      end
      if (bus.PENABLE) begin
        pen++;
        if (acc == w) begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = prd;
          bus.PSLVERR = slv;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = 8'($urandom);
          bus.PSLVERR = 1'($urandom);
        end
        acc++;
      end else begin
        junk_apb();
      end
      step();
      lat++;
    end
    chk("rsp_seen", bus.rsp_valid, 1);
    chk("latency", lat, 2 + acc_exp);
    chk("psel_cycles", psel, 1 + acc_exp);
    chk("penable_cycles", pen, acc_exp);
    chk("addr_stable", stable, 1);
    chk("rsp_rdata", bus.rsp_rdata, rd_exp);
    chk("rsp_err", bus.rsp_err, err_exp);
    chk("rsp_timeout", bus.rsp_timeout, to_exp);
    chk("resp_psel", bus.PSEL, 0);
    chk("resp_cmd_ready", bus.cmd_ready, 0);

    held = 1'b1;
    for (int i = 0; i < d; i++) begin
      junk_cmd();
      junk_apb();
      step();
      if (!bus.rsp_valid || bus.rsp_rdata !== rd_exp || bus.rsp_err !== err_exp ||
          bus.rsp_timeout !== to_exp || bus.cmd_ready) held = 1'b0;
    end
    chk("rsp_hold", held, 1);

    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("next_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int acc_t[$];
    int hi, seen;
    logic quiet;

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    do_reset();

    run_txn(1'b1, 8'h04, 8'hA5, 0, 8'h77, 1'b0, 0);
    run_txn(1'b0, 8'h08, 8'h11, 3, 8'h3C, 1'b0, 0);
    run_txn(1'b0, 8'h0C, 8'h22, 0, 8'h99, 1'b1, 5);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    run_txn(1'b0, 8'h20, 8'h33, 60, 8'hEE, 1'b0, 1);
`else
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h20;
    bus.rsp_ready = 1'b1; bus.PREADY = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    hi = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 8'($urandom);
      bus.PSLVERR = 1'($urandom);
      step();
      if (bus.PSEL) hi++;
      if (bus.rsp_valid) seen++;
    end
    chk("stuck_psel", hi, 100);
    chk("stuck_no_rsp", seen, 0);
    do_reset();
`endif

    // Reset in the middle of ACCESS must drop the transfer without a response.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h30; bus.cmd_wdata = 8'h5A;
    bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("pre_rst_access", bus.PENABLE, 1);
    PRESET = 1'b1;
    step();
    chk("abort_psel", bus.PSEL, 0);
    chk("abort_penable", bus.PENABLE, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    PRESET = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      junk_apb();
      step();
      if (bus.rsp_valid || bus.PSEL) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);
    bus.rsp_ready = 1'b0;
    run_txn(1'b1, 8'h44, 8'hC3, 0, 8'h00, 1'b0, 0);

    // Back-to-back: cmd_valid held, zero-wait target, rsp_ready held.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h50; bus.cmd_wdata = 8'h01;
    bus.rsp_ready = 1'b1; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.cmd_valid && bus.cmd_ready) acc_t.push_back(c);
      bus.cmd_addr = 8'($urandom);
      step();
    end
    chk("b2b_count", acc_t.size(), 8);
    for (int i = 1; i < acc_t.size(); i++) chk("b2b_gap", acc_t[i] - acc_t[i-1], 4);
    bus.cmd_valid = 1'b0;
    do_reset();

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
              8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        junk_apb();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum PREADY-low cycles in ACCESS (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous active-high reset: PCLK input 1, rising-edge clock; PRESET input 1, synchronous active-high reset.
REQ-005 The command port SHALL comprise: cmd_valid in 1, request present; cmd_ready out 1, request accepted; cmd_write in 1, 1=write; cmd_addr in ADDR_W, address; cmd_wdata in DATA_W, write data.
REQ-006 The response port SHALL comprise: rsp_valid out 1, result present; rsp_ready in 1, result taken; rsp_rdata out DATA_W, read data; rsp_err out 1, PSLVERR or timeout; rsp_timeout out 1, transfer timed out.
REQ-007 The APB master port SHALL comprise: PADDR out ADDR_W; PSEL out 1; PENABLE out 1; PWRITE out 1; PWDATA out DATA_W; PRDATA in DATA_W; PREADY in 1; PSLVERR in 1.

Function
REQ-008 The block SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-009 cmd_ready SHALL be 1 only in IDLE.
REQ-010 IDLE SHALL go to SETUP on the edge where cmd_valid=1 and cmd_ready=1, registering cmd_addr, cmd_write and cmd_wdata onto PADDR, PWRITE and PWDATA.
REQ-011 SETUP SHALL drive PSEL=1 and PENABLE=0, then go unconditionally to ACCESS after one cycle.
REQ-012 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL stay in ACCESS while PREADY=0.
REQ-013 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP until ACCESS exits.
REQ-014 On the edge where PREADY=1 in ACCESS, the block SHALL go to RESP and register rsp_rdata=PRDATA (read) or 0 (write), rsp_err=PSLVERR and rsp_timeout=0.
REQ-015 RESP SHALL drive PSEL=0, PENABLE=0 and rsp_valid=1, holding all rsp_* outputs stable until rsp_ready=1.
REQ-016 The block SHALL go from RESP to IDLE on the edge where rsp_valid=1 and rsp_ready=1, with rsp_valid=0 in IDLE.
REQ-017 Minimum latency SHALL be: command accepted at edge E0, SETUP after E0, ACCESS after E1, rsp_valid=1 after E2 when PREADY=1 at E2; next cmd_ready=1 one cycle after the response handshake.
REQ-018 Each wait state (PREADY=0 in ACCESS) SHALL extend the latency by exactly one cycle.
REQ-019 cmd_valid SHALL be ignored outside IDLE; no command SHALL be queued.
REQ-020 PRDATA and PSLVERR SHALL be sampled only on the PREADY=1 ACCESS edge, and SHALL be ignored at all other times.

Reset
REQ-021 PRESET=1 at an edge SHALL force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and the wait counter to 0.
REQ-022 While PRESET=1, cmd_ready SHALL be 0.
REQ-023 A reset during SETUP, ACCESS or RESP SHALL abort the transfer and discard its response, with no rsp_valid issued for it.

Configuration
REQ-024 When macro APB_CMD_MASTER_TIMEOUT_EN is defined, an 8-bit counter SHALL count the PREADY=0 cycles spent in ACCESS.
REQ-025 With the macro defined, when the counter equals TIMEOUT and PREADY=0, the block SHALL go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-026 With the macro defined, a PREADY=1 on the same edge as the limit SHALL take priority and complete normally.
REQ-027 With the macro defined, the counter SHALL clear on every entry to SETUP.
REQ-028 When APB_CMD_MASTER_TIMEOUT_EN is undefined, there SHALL be no counter, ACCESS SHALL wait for PREADY indefinitely, and rsp_timeout SHALL be tied to 0.

Verification
REQ-029 Write addr 0x04 data 0xA5, PREADY=1 -> PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA=0xA5, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-030 Read addr 0x08, PRDATA=0x3C, PREADY low 3 cycles -> ACCESS lasts 4 cycles, rsp_rdata=0x3C, PADDR stable throughout.
REQ-031 Read with PSLVERR=1 on the completing edge, rsp_ready low 5 cycles -> rsp_err=1 held 5 cycles, cmd_ready=0 until the handshake.
REQ-032 With TIMEOUT_EN defined, TIMEOUT=4 and PREADY stuck at 0 -> exit after 4 wait cycles with rsp_err=1 and rsp_timeout=1; with the macro undefined -> PSEL stays high for 100 cycles with no response.
REQ-033 PRESET asserted in ACCESS -> next cycle PSEL=0, PENABLE=0, rsp_valid=0; after release, a new write completes with the normal REQ-017 latency.
REQ-034 Back-to-back commands with cmd_valid held high and rsp_ready=1 -> consecutive accepts spaced exactly 4 cycles apart.
